program_loader: RTL and testbench

- Sits directly upstream of the accumulator CPU.
- Receives a program as a byte stream from the UART receiver and assembles 16-bit instruction words.
- Writes those words sequentially into program memory.
- Holds the CPU in reset until loading completes, then releases it so execution starts at address 0.

---
 rtl/program_loader.sv | 192 +++++++++++++++++++
 tb/tb_program_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: packs UART bytes into instruction words, writes them to
// program memory and holds the CPU in reset until the load ends. Option macro: LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int ADDR_LENGTH        = 11,
   parameter int INSTRUCTION_LENGTH = 16,
   parameter int BYTE_LENGTH        = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [BYTE_LENGTH-1:0]        rx_data,
   input  logic                          rx_done,
   output logic                          pm_we,
   output logic [ADDR_LENGTH-1:0]        pm_addr,
   output logic [INSTRUCTION_LENGTH-1:0] pm_data,
   output logic                          cpu_reset,
   output logic                          loaded,
   output logic                          error,
   output logic [ADDR_LENGTH:0]          instr_count
);

   localparam logic [ADDR_LENGTH-1:0] ADDR_MAX  = {ADDR_LENGTH{1'b1}};
   localparam logic [ADDR_LENGTH-1:0] ADDR_ONE  = {{(ADDR_LENGTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_LENGTH:0]   COUNT_ONE = {{ADDR_LENGTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_WAIT_HI = 3'd0,
      S_WAIT_LO = 3'd1,
      S_WRITE   = 3'd2,
      S_RUN     = 3'd3
`ifdef LOADER_CHECKSUM_EN
      ,
      S_WAIT_CK = 3'd4,
      S_ERROR   = 3'd5
`endif
   } state_e;

   state_e                          state_q, state_d;
   logic [BYTE_LENGTH-1:0]          hi_q, hi_d;
   logic                            pm_we_q, pm_we_d;
   logic [ADDR_LENGTH-1:0]          pm_addr_q, pm_addr_d;
   logic [INSTRUCTION_LENGTH-1:0]   pm_data_q, pm_data_d;
   logic                            cpu_reset_q, cpu_reset_d;
   logic                            loaded_q, loaded_d;
   logic [ADDR_LENGTH:0]            instr_count_q, instr_count_d;
   logic                            terminate_s;
`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_LENGTH-1:0]          xor_q, xor_d;
   logic                            error_q, error_d;
`endif

   // A load ends on the HLT word or when the last memory address has been written.
   assign terminate_s = (pm_data_q == {INSTRUCTION_LENGTH{1'b0}}) || (pm_addr_q == ADDR_MAX);

   // Next-state and next-output logic for the loader FSM.
   always_comb begin
      state_d       = state_q;
      hi_d          = hi_q;
      pm_we_d       = 1'b0;
      pm_addr_d     = pm_addr_q;
      pm_data_d     = pm_data_q;
      cpu_reset_d   = cpu_reset_q;
      loaded_d      = loaded_q;
      instr_count_d = instr_count_q;
`ifdef LOADER_CHECKSUM_EN
      xor_d         = xor_q;
      error_d       = error_q;
`endif
      case (state_q)
         S_WAIT_HI: begin
            if (rx_done) begin
               hi_d    = rx_data;
               state_d = S_WAIT_LO;
`ifdef LOADER_CHECKSUM_EN
               xor_d   = xor_q ^ rx_data;
`endif
            end else begin
               state_d = S_WAIT_HI;
            end
         end
         S_WAIT_LO: begin
            if (rx_done) begin
               pm_data_d = {hi_q, rx_data};
               pm_we_d   = 1'b1;
               state_d   = S_WRITE;
`ifdef LOADER_CHECKSUM_EN
               xor_d     = xor_q ^ rx_data;
`endif
            end else begin
               state_d = S_WAIT_LO;
            end
         end
         S_WRITE: begin
            instr_count_d = instr_count_q + COUNT_ONE;
            if (terminate_s) begin
`ifdef LOADER_CHECKSUM_EN
               state_d     = S_WAIT_CK;
`else
               state_d     = S_RUN;
               cpu_reset_d = 1'b0;
               loaded_d    = 1'b1;
`endif
            end else begin
               pm_addr_d = pm_addr_q + ADDR_ONE;
               // A byte landing in the write cycle is the next word's high byte.
               if (rx_done) begin
                  hi_d    = rx_data;
                  state_d = S_WAIT_LO;
`ifdef LOADER_CHECKSUM_EN
                  xor_d   = xor_q ^ rx_data;
`endif
               end else begin
                  state_d = S_WAIT_HI;
               end
            end
         end
         S_RUN: begin
            state_d     = S_RUN;
            cpu_reset_d = 1'b0;
            loaded_d    = 1'b1;
         end
`ifdef LOADER_CHECKSUM_EN
         S_WAIT_CK: begin
            if (rx_done) begin
               if (rx_data == xor_q) begin
                  state_d     = S_RUN;
                  cpu_reset_d = 1'b0;
                  loaded_d    = 1'b1;
               end else begin
                  state_d     = S_ERROR;
                  error_d     = 1'b1;
               end
            end else begin
               state_d = S_WAIT_CK;
            end
         end
         S_ERROR: begin
            state_d     = S_ERROR;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
            loaded_d    = 1'b0;
         end
`endif
         default: begin
            state_d = S_WAIT_HI;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_WAIT_HI;
         hi_q          <= {BYTE_LENGTH{1'b0}};
         pm_we_q       <= 1'b0;
         pm_addr_q     <= {ADDR_LENGTH{1'b0}};
         pm_data_q     <= {INSTRUCTION_LENGTH{1'b0}};
         cpu_reset_q   <= 1'b1;
         loaded_q      <= 1'b0;
         instr_count_q <= {(ADDR_LENGTH+1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
         xor_q         <= {BYTE_LENGTH{1'b0}};
         error_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         hi_q          <= hi_d;
         pm_we_q       <= pm_we_d;
         pm_addr_q     <= pm_addr_d;
         pm_data_q     <= pm_data_d;
         cpu_reset_q   <= cpu_reset_d;
         loaded_q      <= loaded_d;
         instr_count_q <= instr_count_d;
`ifdef LOADER_CHECKSUM_EN
         xor_q         <= xor_d;
         error_q       <= error_d;
`endif
      end
   end

   assign pm_we       = pm_we_q;
   assign pm_addr     = pm_addr_q;
   assign pm_data     = pm_data_q;
   assign cpu_reset   = cpu_reset_q;
   assign loaded      = loaded_q;
   assign instr_count = instr_count_q;
`ifdef LOADER_CHECKSUM_EN
   assign error       = error_q;
`else
   assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; honours LOADER_CHECKSUM_EN when defined.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_done = 1'b0;
   logic        pm_we;
   logic [10:0] pm_addr;
   logic [15:0] pm_data;
   logic        cpu_reset;
   logic        loaded;
   logic        error;
   logic [11:0] instr_count;

   int total = 0;
   int bad = 0;

   logic [10:0] log_addr[$];
   logic [15:0] log_data[$];

   program_loader dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .pm_we(pm_we), .pm_addr(pm_addr), .pm_data(pm_data), .cpu_reset(cpu_reset),
      .loaded(loaded), .error(error), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Record every memory write seen on the falling edge.
   always @(negedge clk) begin
      if (pm_we === 1'b1) begin
         log_addr.push_back(pm_addr);
         log_data.push_back(pm_data);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      rx_done = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      log_addr.delete();
      log_data.delete();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (pm_we !== 1'b0) begin $display("FAIL rst_pm_we: got %b want 0", pm_we); bad++; end
      total++; if (pm_addr !== 11'd0) begin $display("FAIL rst_pm_addr: got %h want 000", pm_addr); bad++; end
      total++; if (pm_data !== 16'h0000) begin $display("FAIL rst_pm_data: got %h want 0000", pm_data); bad++; end
      total++; if (cpu_reset !== 1'b1) begin $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); bad++; end
      total++; if (loaded !== 1'b0) begin $display("FAIL rst_loaded: got %b want 0", loaded); bad++; end
      total++; if (error !== 1'b0) begin $display("FAIL rst_error: got %b want 0", error); bad++; end
      total++; if (instr_count !== 12'd0) begin $display("FAIL rst_count: got %0d want 0", instr_count); bad++; end
   endtask

   task automatic test_basic();
      do_reset();
      send_byte(8'h08);
      send_byte(8'h05);
      total++; if (cpu_reset !== 1'b1) begin $display("FAIL basic_held: cpu_reset got %b want 1", cpu_reset); bad++; end
      idle();
      send_byte(8'h00);
      send_byte(8'h00);
      total++; if (pm_we !== 1'b1 || pm_addr !== 11'd1 || pm_data !== 16'h0000)
         begin $display("FAIL basic_hlt_write: got we=%b addr=%h data=%h want we=1 addr=001 data=0000", pm_we, pm_addr, pm_data); bad++; end
      idle();
`ifdef LOADER_CHECKSUM_EN
      total++; if (loaded !== 1'b0 || cpu_reset !== 1'b1)
         begin $display("FAIL basic_wait_ck: got loaded=%b cpu_reset=%b want 0/1", loaded, cpu_reset); bad++; end
`else
      total++; if (loaded !== 1'b1 || cpu_reset !== 1'b0)
         begin $display("FAIL basic_release: got loaded=%b cpu_reset=%b want 1/0", loaded, cpu_reset); bad++; end
`endif
      send_byte(8'h0D);
      total++; if (loaded !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0)
         begin $display("FAIL basic_run: got loaded=%b cpu_reset=%b error=%b want 1/0/0", loaded, cpu_reset, error); bad++; end
      total++; if (instr_count !== 12'd2 || pm_addr !== 11'd1 || pm_we !== 1'b0)
         begin $display("FAIL basic_final: got count=%0d addr=%h we=%b want 2/001/0", instr_count, pm_addr, pm_we); bad++; end
      total++;
      if (log_addr.size() != 2) begin $display("FAIL basic_log_size: got %0d want 2", log_addr.size()); bad++; end
      else if (log_addr[0] !== 11'd0 || log_data[0] !== 16'h0805 || log_addr[1] !== 11'd1 || log_data[1] !== 16'h0000)
         begin $display("FAIL basic_log: got %h:%h %h:%h want 000:0805 001:0000", log_addr[0], log_data[0], log_addr[1], log_data[1]); bad++; end
   endtask

   task automatic test_reset_midload();
      do_reset();
      send_byte(8'h12);
      reset = 1'b1;
      rx_data = 8'h77;
      rx_done = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rx_done = 1'b0;
      total++; if (pm_we !== 1'b0 || instr_count !== 12'd0 || cpu_reset !== 1'b1)
         begin $display("FAIL mid_reset_state: got we=%b count=%0d cpu_reset=%b want 0/0/1", pm_we, instr_count, cpu_reset); bad++; end
      send_byte(8'h34);
      send_byte(8'h56);
      idle();
      send_byte(8'h00);
      send_byte(8'h00);
      idle();
      send_byte(8'h62);
      idle();
      total++;
      if (log_addr.size() != 2) begin $display("FAIL mid_log_size: got %0d want 2", log_addr.size()); bad++; end
      else if (log_addr[0] !== 11'd0 || log_data[0] !== 16'h3456)
         begin $display("FAIL mid_first_word: got %h:%h want 000:3456", log_addr[0], log_data[0]); bad++; end
      total++; if (instr_count !== 12'd2 || loaded !== 1'b1)
         begin $display("FAIL mid_final: got count=%0d loaded=%b want 2/1", instr_count, loaded); bad++; end
   endtask

   task automatic test_full_memory();
      int errs;
      do_reset();
      for (int i = 0; i < 2048; i++) begin
         send_byte(8'h08);
         send_byte(8'h01);
      end
      total++; if (pm_we !== 1'b1 || pm_addr !== 11'd2047)
         begin $display("FAIL full_last_write: got we=%b addr=%0d want 1/2047", pm_we, pm_addr); bad++; end
      idle();
      send_byte(8'h00);
      idle();
      total++; if (loaded !== 1'b1 || pm_addr !== 11'd2047 || instr_count !== 12'd2048)
         begin $display("FAIL full_run: got loaded=%b addr=%0d count=%0d want 1/2047/2048", loaded, pm_addr, instr_count); bad++; end
      errs = 0;
      if (log_addr.size() != 2048) errs = 1;
      else
         for (int i = 0; i < 2048; i++)
            if (log_addr[i] !== i[10:0] || log_data[i] !== 16'h0801) errs++;
      total++; if (errs != 0) begin $display("FAIL full_log: size=%0d bad_entries=%0d want 2048/0", log_addr.size(), errs); bad++; end
      send_byte(8'hFF);
      idle();
      idle();
      total++; if (log_addr.size() != 2048 || pm_addr !== 11'd2047)
         begin $display("FAIL full_after_run: got writes=%0d addr=%0d want 2048/2047", log_addr.size(), pm_addr); bad++; end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_byte(8'hA1);
      send_byte(8'hB2);
      send_byte(8'hC3);
      send_byte(8'hD4);
      send_byte(8'h00);
      send_byte(8'h00);
      total++; if (pm_we !== 1'b1 || pm_addr !== 11'd2)
         begin $display("FAIL b2b_hlt_write: got we=%b addr=%h want 1/002", pm_we, pm_addr); bad++; end
      idle();
      send_byte(8'h04);
      idle();
      total++;
      if (log_addr.size() != 3) begin $display("FAIL b2b_log_size: got %0d want 3", log_addr.size()); bad++; end
      else if (log_addr[0] !== 11'd0 || log_data[0] !== 16'hA1B2 || log_addr[1] !== 11'd1 || log_data[1] !== 16'hC3D4 ||
               log_addr[2] !== 11'd2 || log_data[2] !== 16'h0000)
         begin $display("FAIL b2b_log: got %h:%h %h:%h %h:%h want 000:a1b2 001:c3d4 002:0000",
                        log_addr[0], log_data[0], log_addr[1], log_data[1], log_addr[2], log_data[2]); bad++; end
      total++; if (instr_count !== 12'd3 || loaded !== 1'b1)
         begin $display("FAIL b2b_final: got count=%0d loaded=%b want 3/1", instr_count, loaded); bad++; end
   endtask

   task automatic test_after_run();
      send_byte(8'hFF);
      send_byte(8'hFF);
      idle();
      idle();
      total++; if (log_addr.size() != 3 || instr_count !== 12'd3 || pm_we !== 1'b0 || loaded !== 1'b1)
         begin $display("FAIL after_run: got writes=%0d count=%0d we=%b loaded=%b want 3/3/0/1",
                        log_addr.size(), instr_count, pm_we, loaded); bad++; end
   endtask

   task automatic test_odd_bytes();
      do_reset();
      send_byte(8'h55);
      repeat (6) idle();
      total++; if (cpu_reset !== 1'b1 || loaded !== 1'b0 || log_addr.size() != 0 || instr_count !== 12'd0)
         begin $display("FAIL odd_stall: got cpu_reset=%b loaded=%b writes=%0d count=%0d want 1/0/0/0",
                        cpu_reset, loaded, log_addr.size(), instr_count); bad++; end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      do_reset();
      send_byte(8'h08); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
      idle();
      send_byte(8'h0D);
      idle();
      total++; if (loaded !== 1'b1 || error !== 1'b0 || cpu_reset !== 1'b0)
         begin $display("FAIL ck_good: got loaded=%b error=%b cpu_reset=%b want 1/0/0", loaded, error, cpu_reset); bad++; end
      do_reset();
      send_byte(8'h08); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
      idle();
      send_byte(8'h0C);
      idle();
      total++; if (loaded !== 1'b0 || error !== 1'b1 || cpu_reset !== 1'b1)
         begin $display("FAIL ck_bad: got loaded=%b error=%b cpu_reset=%b want 0/1/1", loaded, error, cpu_reset); bad++; end
      send_byte(8'h0D);
      idle();
      total++; if (loaded !== 1'b0 || error !== 1'b1)
         begin $display("FAIL ck_error_sticky: got loaded=%b error=%b want 0/1", loaded, error); bad++; end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_reset_midload();
      test_full_memory();
      test_back_to_back();
      test_after_run();
      test_odd_bytes();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
